puf_rng_sample_packer: RTL and testbench
========================================

# puf_rng_sample_packer

Downstream consumer of the PUF core's RNG-mode 2-bit output stream. Accepts 2-bit samples on a strobe, packs 16 samples into a 32-bit word, buffers words in a small FIFO, and presents them on a valid/ready read port toward the register/bus interface. Optionally runs a repetition-count health test on the raw samples and quarantines output on failure.

## Interface
- `FIFO_DEPTH`, 4: number of 32-bit words buffered; power of two, ≥2.
- `REP_LIMIT`, 16: run length of identical consecutive samples that declares a health failure; range 2..255.

- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `enable`  in  1: packer enable; low discards incoming samples and clears the partial word.
- `sample_valid`  in  1: one-cycle strobe; a new 2-bit sample is present (driven by the core's 2-bit done).
- `sample`  in  2: sample value, sampled when `sample_valid`=1.
- `rd_ready`  in  1: consumer accepts the head word.
- `rd_valid`  out  1: FIFO non-empty.
- `rd_data`  out  32: FIFO head word.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1): words currently held.
- `overflow`  out  1: sticky; a completed word was dropped because the FIFO was full.
- `health_fail`  out  1: sticky; repetition test tripped.
- `clear`  in  1: one-cycle pulse; clears `overflow`, `health_fail`, and the run counter.

## Operation
- Accept: sample taken on an edge where `enable`=1, `sample_valid`=1, `health_fail`=0.
- Packing: LSB first; k-th accepted sample (k=0..15) lands in bits [2k+1:2k] of the partial word. A 4-bit sample counter wraps 15→0.
- Push: on the edge accepting sample 15, the completed word (including that sample) is written to the FIFO tail on that same edge.
- Full: if the FIFO is full and no pop occurs that edge, the word is dropped and `overflow` sets. If a pop occurs on the same edge, the push succeeds and the level stays at FIFO_DEPTH.
- Pop: on any edge with `rd_valid`=1 and `rd_ready`=1. Pointers wrap modulo FIFO_DEPTH.
- `enable`=0: sample counter and partial word clear on the next edge. FIFO contents and sticky flags are kept, and pops continue.
- Health test (macro on): run counter tracks the current run of identical accepted samples; it resets to 1 whenever the sample differs from the previous one.
  - When the run reaches REP_LIMIT, `health_fail` sets on that edge and the partial word (including the current sample) is discarded, with no push even if it was sample 15.
  - Further samples are ignored until `clear`. Words already in the FIFO remain readable.
- `clear`: on the same edge as a new overflow or health event, the set wins. `clear` also resets the sample counter and partial word.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `fifo_level`=0, `overflow`=0, `health_fail`=0; all counters and pointers are 0.
- Latency: with the FIFO empty, 16th sample accepted at edge N → `rd_valid`=1 and `rd_data` valid after edge N.
- `rd_data` is held stable while `rd_valid`=1 and there is no pop. After a pop it advances to the next word on the following cycle.
- Samples may arrive on consecutive cycles; throughput is one sample per cycle.
- `rst` asserted mid-word or mid-read returns to the reset state immediately. In-flight data is lost.

## Configuration
- `PUF_RNG_HEALTH_EN` defined: run counter and health logic are present as described.
- Undefined: no run counter; `health_fail` is tied to 0 and samples are never quarantined. `clear` still clears `overflow`.

## Test plan
- Samples 0,1,2,3 repeated ×4, `rd_ready`=1 → one word 0xE4E4E4E4; `rd_valid` high the cycle after the 16th strobe; `fifo_level` goes 1 then 0.
- FIFO_DEPTH=4, `rd_ready`=0, 5 words of distinct patterns → `fifo_level`=4, `overflow`=1, and reads return the first 4 words in order.
- FIFO full and 16th sample coinciding with a pop → no overflow, `fifo_level` stays 4, and the new word appears last.
- Macro on, REP_LIMIT=16: 16 samples of 2'b01 → `health_fail`=1 on the 16th edge, no word pushed, later samples ignored. After `clear`, samples 0..3×4 → 0xE4E4E4E4.
- `enable` dropped after 7 samples, then re-enabled with 16 samples of 2'b11 → one word 0xFFFFFFFF (macro off or REP_LIMIT>16); the stale partial word is discarded.
- `rst` pulsed with 2 words queued and 5 samples pending → all outputs return to their reset values; the next 16 samples produce exactly one word.

Source files
------------

// File: rtl/puf_rng_sample_packer.sv
// -----------------------------------------------------------------------------
// puf_rng_sample_packer
//
// Packs the PUF core's RNG-mode 2-bit samples into 32-bit words (16 samples,
// LSB first) and buffers the words in a small FIFO. The FIFO is read through a
// valid/ready port.
//
// Optional feature macro: PUF_RNG_HEALTH_EN
//   defined   - repetition-count health test on accepted samples. A run of
//               REP_LIMIT identical samples sets health_fail and discards the
//               partial word. Samples are then ignored until clear.
//   undefined - no run counter; health_fail is held at 0.
//
// Parameters
//   FIFO_DEPTH   words buffered (power of two, >= 2)
//   REP_LIMIT    run length that trips the health test (2..255)
//
// Ports
//   clk           clock
//   rst           asynchronous active-high reset
//   enable        packer enable; low clears the partial word and sample count
//   sample_valid  strobe marking a new 2-bit sample
//   sample        2-bit sample value
//   rd_ready      consumer accepts the head word
//   rd_valid      FIFO non-empty
//   rd_data       FIFO head word
//   fifo_level    number of words held
//   overflow      sticky: a completed word was dropped on a full FIFO
//   health_fail   sticky: repetition test tripped
//   clear         pulse: clears sticky flags, run counter and partial word
// -----------------------------------------------------------------------------
module puf_rng_sample_packer #(
   parameter int FIFO_DEPTH = 4,
   parameter int REP_LIMIT  = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enable,
   input  logic                            sample_valid,
   input  logic [1:0]                      sample,
   input  logic                            rd_ready,
   output logic                            rd_valid,
   output logic [31:0]                     rd_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
   output logic                            overflow,
   output logic                            health_fail,
   input  logic                            clear
);

   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   partial_q, partial_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          rd_valid_q;
   logic          overflow_q, overflow_d;
   logic          health_q, health_d;
   logic [31:0]   mem_q [FIFO_DEPTH];

   logic          accept_s;
   logic          last_s;
   logic          trip_s;
   logic          push_req_s;
   logic          pop_s;
   logic          full_s;
   logic          push_ok_s;
   logic          drop_s;
   logic [31:0]   word_s;

   assign accept_s = enable & sample_valid & ~health_q;
   assign last_s   = (cnt_q == 4'd15);
   // Bits [31:30] of the partial word are always zero here, so OR-ing the
   // final sample in completes the word.
   assign word_s   = partial_q | {sample, 30'd0};

`ifdef PUF_RNG_HEALTH_EN
   logic [7:0] run_q, run_d, run_next_s;
   logic [1:0] prev_q, prev_d;

   // Length of the run the incoming sample would extend or start.
   always_comb begin
      if ((run_q != 8'd0) && (sample == prev_q)) begin
         run_next_s = run_q + 8'd1;
      end else begin
         run_next_s = 8'd1;
      end
   end

   assign trip_s = accept_s & (run_next_s >= 8'(REP_LIMIT));

   // Next state of the run counter and the last accepted sample.
   always_comb begin
      run_d  = run_q;
      prev_d = prev_q;
      if (clear) begin
         run_d = 8'd0;
      end else if (accept_s) begin
         run_d  = run_next_s;
         prev_d = sample;
      end else begin
         run_d = run_q;
      end
   end

   // Run counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q  <= 8'd0;
         prev_q <= 2'd0;
      end else begin
         run_q  <= run_d;
         prev_q <= prev_d;
      end
   end
`else
   assign trip_s = 1'b0;
`endif

   assign push_req_s = accept_s & last_s & ~trip_s;
   assign pop_s      = rd_valid_q & rd_ready;
   assign full_s     = (level_q == LEVEL_FULL);
   // A pop on the same edge frees the slot the new word needs.
   assign push_ok_s  = push_req_s & (~full_s | pop_s);
   assign drop_s     = push_req_s & full_s & ~pop_s;

   // Sample counter and partial word next state.
   always_comb begin
      cnt_d     = cnt_q;
      partial_d = partial_q;
      if (clear || !enable || trip_s) begin
         cnt_d     = 4'd0;
         partial_d = 32'd0;
      end else if (accept_s) begin
         if (last_s) begin
            cnt_d     = 4'd0;
            partial_d = 32'd0;
         end else begin
            cnt_d = cnt_q + 4'd1;
            partial_d[{cnt_q, 1'b0} +: 2] = sample;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // FIFO pointer, level and sticky flag next state.
   always_comb begin
      wr_ptr_d = push_ok_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
      case ({push_ok_s, pop_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      // A new event on the same edge as clear wins.
      if (drop_s) begin
         overflow_d = 1'b1;
      end else if (clear) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
      if (trip_s) begin
         health_d = 1'b1;
      end else if (clear) begin
         health_d = 1'b0;
      end else begin
         health_d = health_q;
      end
   end

   // Control and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= 4'd0;
         partial_q  <= 32'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
         health_q   <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         partial_q  <= partial_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         rd_valid_q <= (level_d != LW'(0));
         overflow_q <= overflow_d;
         health_q   <= health_d;
      end
   end

   // FIFO storage; cleared on reset so rd_data reads zero out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 32'd0;
         end
      end else if (push_ok_s) begin
         mem_q[wr_ptr_q] <= word_s;
      end else begin
         mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
   end

   assign rd_valid    = rd_valid_q;
   assign rd_data     = mem_q[rd_ptr_q];
   assign fifo_level  = level_q;
   assign overflow    = overflow_q;
   assign health_fail = health_q;

endmodule

// File: tb/tb_puf_rng_sample_packer.sv
// -----------------------------------------------------------------------------
// Testbench for puf_rng_sample_packer (FIFO_DEPTH=4, REP_LIMIT=16).
// Expected words come from a vector table and hand-written constants; a queue
// scoreboard receives each word when its 16th sample is driven and compares it
// when the DUT presents it. Health-test sequences are built only when
// PUF_RNG_HEALTH_EN is defined.
// -----------------------------------------------------------------------------
module tb_puf_rng_sample_packer;

   localparam int DEPTH = 4;
   localparam int REP   = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        sample_valid;
   logic [1:0]  sample;
   logic        rd_ready;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic        health_fail;
   logic        clear;

   always #5 clk = ~clk;

   puf_rng_sample_packer #(.FIFO_DEPTH(DEPTH), .REP_LIMIT(REP)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .sample_valid (sample_valid),
      .sample       (sample),
      .rd_ready     (rd_ready),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .health_fail  (health_fail),
      .clear        (clear)
   );

   typedef struct {
      logic [1:0]  base;
      logic [1:0]  inc;
      bit          gap;
      logic [31:0] word;
   } vec_t;

   vec_t        vecs[5];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb[$];
   logic [31:0] exp_word;
   int          cnt_m;
   int          run_m;
   logic [1:0]  prev_m;
   bit          hf_m;
   bit          ov_m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      cnt_m  = 0;
      run_m  = 0;
      prev_m = 2'd0;
      hf_m   = 1'b0;
      ov_m   = 1'b0;
      sb.delete();
   endtask

   // Compare outputs against the model, update the model for the coming
   // edge, then advance to 1 time unit after that edge.
   task automatic step();
      bit pop_m, acc_m, trip_m, push_m;
      chk("rd_valid", 32'(rd_valid), 32'(sb.size() != 0));
      chk("fifo_level", 32'(fifo_level), 32'(sb.size()));
      chk("overflow", 32'(overflow), 32'(ov_m));
      chk("health_fail", 32'(health_fail), 32'(hf_m));
      if (sb.size() != 0) chk("rd_data", rd_data, sb[0]);
      pop_m  = (sb.size() != 0) && rd_ready;
      acc_m  = enable && sample_valid && !hf_m;
      trip_m = 1'b0;
      push_m = 1'b0;
      if (acc_m) begin
`ifdef PUF_RNG_HEALTH_EN
         run_m  = (run_m != 0 && sample == prev_m) ? run_m + 1 : 1;
         prev_m = sample;
         trip_m = (run_m >= REP);
`endif
         if (trip_m) hf_m = 1'b1;
         else if (cnt_m == 15) push_m = 1'b1;
         cnt_m = (trip_m || cnt_m == 15) ? 0 : cnt_m + 1;
      end
      if (!enable) cnt_m = 0;
      if (clear) begin
         cnt_m = 0;
         run_m = 0;
         ov_m  = 1'b0;
         if (!trip_m) hf_m = 1'b0;
      end
      if (pop_m) void'(sb.pop_front());
      if (push_m) begin
         if (sb.size() < DEPTH) sb.push_back(exp_word);
         else ov_m = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [1:0] s, input bit gap);
      sample_valid = 1'b1;
      sample       = s;
      step();
      sample_valid = 1'b0;
      sample       = 2'd0;
      if (gap) step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send_vec(input vec_t v, input int nsamp);
      exp_word = v.word;
      for (int k = 0; k < nsamp; k++) put(2'(v.base + 2'(k) * v.inc), v.gap);
   endtask

   initial begin
      vecs[0] = '{base: 2'd0, inc: 2'd1, gap: 1'b0, word: 32'hE4E4E4E4};
      vecs[1] = '{base: 2'd3, inc: 2'd3, gap: 1'b1, word: 32'h1B1B1B1B};
      vecs[2] = '{base: 2'd1, inc: 2'd2, gap: 1'b0, word: 32'hDDDDDDDD};
      vecs[3] = '{base: 2'd0, inc: 2'd2, gap: 1'b1, word: 32'h88888888};
      vecs[4] = '{base: 2'd1, inc: 2'd1, gap: 1'b0, word: 32'h39393939};

      rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample = 2'd0;
      rd_ready = 1'b0; clear = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rd_valid", 32'(rd_valid), 32'd0);
      chk("reset_rd_data", rd_data, 32'd0);
      chk("reset_level", 32'(fifo_level), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);
      chk("reset_health", 32'(health_fail), 32'd0);
      rst = 1'b0;
      enable = 1'b1;
      step();

      // Single word, latency and drain.
      rd_ready = 1'b1;
      send_vec(vecs[0], 16);
      chk("latency_valid", 32'(rd_valid), 32'd1);
      chk("latency_data", rd_data, 32'hE4E4E4E4);
      chk("latency_level", 32'(fifo_level), 32'd1);
      idle(2);
      chk("drained_level", 32'(fifo_level), 32'd0);

      // Table: every vector packed and read back.
      for (int i = 0; i < 5; i++) begin
         send_vec(vecs[i], 16);
         idle(2);
      end

      // Overflow: five words into a four-deep FIFO with no reads.
      rd_ready = 1'b0;
      for (int i = 0; i < 5; i++) send_vec(vecs[i], 16);
      chk("ovf_level", 32'(fifo_level), 32'd4);
      chk("ovf_flag", 32'(overflow), 32'd1);
      rd_ready = 1'b1;
      idle(5);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);

      // Full FIFO with the 16th sample coinciding with a pop.
      rd_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_vec(vecs[i], 16);
      send_vec(vecs[4], 15);
      rd_ready = 1'b1;
      put(2'd0, 1'b0);
      rd_ready = 1'b0;
      chk("fullpop_level", 32'(fifo_level), 32'd4);
      chk("fullpop_ovf", 32'(overflow), 32'd0);
      rd_ready = 1'b1;
      idle(5);

`ifdef PUF_RNG_HEALTH_EN
      // Repetition failure, quarantine, then recovery after clear.
      exp_word = 32'h55555555;
      for (int k = 0; k < 16; k++) put(2'd1, 1'b0);
      chk("health_set", 32'(health_fail), 32'd1);
      chk("health_nopush", 32'(fifo_level), 32'd0);
      for (int k = 0; k < 5; k++) put(2'(k), 1'b0);
      chk("health_ignored", 32'(fifo_level), 32'd0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("health_cleared", 32'(health_fail), 32'd0);
      send_vec(vecs[0], 16);
      chk("health_recover", rd_data, 32'hE4E4E4E4);
      idle(2);
`endif

      // Enable dropped mid-word: the stale partial word is discarded.
      for (int k = 0; k < 7; k++) put(2'(k), 1'b0);
      enable = 1'b0;
      step();
      enable = 1'b1;
`ifdef PUF_RNG_HEALTH_EN
      exp_word = 32'hBBBBBBBB;
      for (int k = 0; k < 16; k++) put((k % 2 == 0) ? 2'd3 : 2'd2, 1'b0);
      chk("enable_word", rd_data, 32'hBBBBBBBB);
`else
      exp_word = 32'hFFFFFFFF;
      for (int k = 0; k < 16; k++) put(2'd3, 1'b0);
      chk("enable_word", rd_data, 32'hFFFFFFFF);
`endif
      idle(3);

      // Reset with two words queued and five samples pending.
      rd_ready = 1'b0;
      send_vec(vecs[1], 16);
      send_vec(vecs[2], 16);
      send_vec(vecs[3], 5);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd_ready = 1'b1;
      send_vec(vecs[4], 16);
      chk("post_rst_word", rd_data, 32'h39393939);
      chk("post_rst_level", 32'(fifo_level), 32'd1);
      idle(3);
      chk("post_rst_empty", 32'(fifo_level), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
